mu_dma_sched: RTL
=================

Name: mu_dma_sched

Overview:
- Command scheduler that sequences the MU write-DMA and read-DMA engines.
- CU-side logic pushes DMA descriptors into an in-order queue. The block dispatches each head descriptor to its target engine with a req/idle handshake.
- Tracks engine completions and raises a completion interrupt.
- Sits between the MU register/CU command decode and the dma_wr_* / dma_rd_* engine interfaces.

Parameters:
DEPTH, 4, command queue depth; power of 2, minimum 2
CNT_W, 8, width of the completion counter
TIMEOUT_CYC, 65535, cycles allowed in REQ+BUSY before abort (used only with the optional feature)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
cmd_valid  in  1  descriptor valid
cmd_ready  out  1  queue can accept
cmd_type  in  1  0 = write engine, 1 = read engine
cmd_addr/cmd_len/cmd_num/cmd_inc/cmd_resp_addr  in  32 each  descriptor fields
flush  in  1  drop all queued, not-yet-dispatched descriptors
dma_wr_req  out  1  write engine request
dma_wr_reg_addr/_len/_num/_inc, dma_wr_resp_addr  out  32 each  write descriptor
dma_wr_idle  in  1  write engine idle
dma_rd_req  out  1  read engine request
dma_rd_reg_addr/_len/_num/_inc, dma_rd_resp_addr  out  32 each  read descriptor
dma_rd_idle  in  1  read engine idle
irq_en  in  1  interrupt enable
irq_clr  in  1  clear-pulse for done count and errors
interrupt  out  1  completion interrupt (level)
done_cnt  out  CNT_W  completions since last clear
busy  out  1  queue non-empty or any engine not IDLE
err_wr, err_rd  out  1 each  sticky timeout flags

Behaviour:
- Reset: all outputs 0, except cmd_ready = 1. Queue is empty; both engine FSMs are IDLE.
- Queue:
  - cmd_ready = !full.
  - A push occurs when cmd_valid && cmd_ready.
  - Strictly in-order. A blocked head stalls all entries behind it.
- Dispatch:
  - Evaluated each cycle. At most one dispatch per cycle.
  - If the queue is non-empty, flush = 0, and the head's target FSM is IDLE: pop the head and register its fields onto that engine's outputs.
  - The FSM enters REQ and dma_x_req = 1 in the next cycle.
  - A push and a pop in the same cycle are legal; the occupancy count is unchanged.
  - A push into an empty queue is dispatched no earlier than the cycle after the push.
- Per-engine FSM:
  - IDLE -> REQ on dispatch.
  - REQ: req held at 1. When the sampled dma_x_idle = 0, go to BUSY and drop req.
  - BUSY: when the sampled dma_x_idle = 1, go to IDLE and pulse an internal done.
  - The idle input is ignored while the FSM is IDLE.
  - Descriptor outputs hold their last value until the next dispatch.
- Write and read FSMs operate concurrently. One write and one read may be outstanding at the same time.
- Completion counter:
  - done_cnt += number of done pulses this cycle (0, 1 or 2). Saturates at all-ones.
  - irq_clr with a simultaneous done: done_cnt = number of dones in that cycle.
  - interrupt = irq_en && (done_cnt != 0), registered (one cycle after done_cnt changes).
- flush:
  - Empties the queue in one cycle and blocks both dispatch and push in that cycle.
  - Engines in REQ/BUSY are unaffected and complete normally.
- busy is combinational from the queue-empty and FSM states.

Optional Feature:
MU_DMA_TIMEOUT_EN:
- Defined:
  - Each engine has a counter that clears on entry to REQ and increments in REQ/BUSY.
  - On reaching TIMEOUT_CYC the FSM forces IDLE, drops req and sets err_x.
  - No done is counted for an aborted command.
  - err_x is cleared by irq_clr.
  - interrupt = irq_en && (done_cnt != 0 || err_wr || err_rd).
- Not defined: no counters are built; err_wr and err_rd are tied to 0.

Decomposition:
- Package mu_dma_pkg:
  - Descriptor struct dma_desc_t (type + 5x32 fields).
  - Engine FSM enum {ST_IDLE, ST_REQ, ST_BUSY}.
  - Constants DMA_T_WR = 0, DMA_T_RD = 1.
- Sub-module mu_dma_cmd_fifo:
  - Synchronous FIFO of dma_desc_t, depth DEPTH.
  - Ports: push, pop, flush, full, empty, head.
  - Instantiated once.
- Engine FSMs are two instances of identical logic in a generate loop.

Test Plan:
- Push a WR descriptor (addr 0x1000, len 0x40); hold dma_wr_idle = 1 for 3 cycles after req, then 0, then 1 after 5 cycles -> req high exactly until the idle fall; done_cnt = 1; interrupt = 1 with irq_en = 1.
- Push WR, WR, RD while the write engine stays busy -> second WR blocks the head and the RD is not dispatched until the first WR completes; order of req pulses is WR, WR, RD.
- Push WR then RD, with both engines completing in the same cycle -> done_cnt increments by 2 in one cycle.
- Fill a DEPTH = 4 queue with 4 descriptors while the engines are stalled -> cmd_ready = 0; a 5th cmd_valid is not accepted; flush -> queue empty, cmd_ready = 1, the in-flight engine still completes.
- done_cnt = 0xFF plus an additional done -> stays 0xFF; irq_clr coincident with a done -> done_cnt = 1.
- (MU_DMA_TIMEOUT_EN, TIMEOUT_CYC = 16) dispatch WR and never drop idle -> req drops at cycle 16, err_wr = 1, done_cnt unchanged, interrupt = 1; irq_clr -> err_wr = 0.

Source files
------------

// File: rtl/mu_dma_pkg.sv
// Shared types for the MU DMA command scheduler: descriptor layout, engine
// FSM states and engine-type encodings.
package mu_dma_pkg;

    localparam logic DMA_T_WR = 1'b0;
    localparam logic DMA_T_RD = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_BUSY
    } eng_st_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] len;
        logic [31:0] num;
        logic [31:0] inc;
        logic [31:0] resp_addr;
    } dma_fields_t;

    typedef struct packed {
        logic        typ;
        dma_fields_t f;
    } dma_desc_t;

endpackage

// File: rtl/mu_dma_cmd_fifo.sv
// In-order descriptor queue for the DMA scheduler. A flush empties it in one
// cycle and takes priority over any push/pop in that cycle.
module mu_dma_cmd_fifo
    import mu_dma_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      push,
    input  logic      pop,
    input  logic      flush,
    input  dma_desc_t din,
    output logic      full,
    output logic      empty,
    output dma_desc_t head
);

    localparam int AW = $clog2(DEPTH);

    dma_desc_t     mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [AW:0]   cnt;
    logic          do_push;
    logic          do_pop;

    assign full    = (cnt == (AW+1)'(DEPTH));
    assign empty   = (cnt == '0);
    assign head    = mem[rptr];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= din;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else if (flush) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
            cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

endmodule

// File: rtl/mu_dma_sched.sv
// MU DMA command scheduler: in-order queue feeding the write/read DMA engines.
// Optional per-engine watchdog abort is built when MU_DMA_TIMEOUT_EN is defined.
module mu_dma_sched
    import mu_dma_pkg::*;
#(
    parameter int DEPTH       = 4,
    parameter int CNT_W       = 8,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_type,
    input  logic [31:0]      cmd_addr,
    input  logic [31:0]      cmd_len,
    input  logic [31:0]      cmd_num,
    input  logic [31:0]      cmd_inc,
    input  logic [31:0]      cmd_resp_addr,
    input  logic             flush,
    output logic             dma_wr_req,
    output logic [31:0]      dma_wr_reg_addr,
    output logic [31:0]      dma_wr_reg_len,
    output logic [31:0]      dma_wr_reg_num,
    output logic [31:0]      dma_wr_reg_inc,
    output logic [31:0]      dma_wr_resp_addr,
    input  logic             dma_wr_idle,
    output logic             dma_rd_req,
    output logic [31:0]      dma_rd_reg_addr,
    output logic [31:0]      dma_rd_reg_len,
    output logic [31:0]      dma_rd_reg_num,
    output logic [31:0]      dma_rd_reg_inc,
    output logic [31:0]      dma_rd_resp_addr,
    input  logic             dma_rd_idle,
    input  logic             irq_en,
    input  logic             irq_clr,
    output logic             interrupt,
    output logic [CNT_W-1:0] done_cnt,
    output logic             busy,
    output logic             err_wr,
    output logic             err_rd
);

    dma_desc_t         din;
    dma_desc_t         head;
    logic              full;
    logic              empty;
    logic              push;
    logic              disp;
    logic [1:0]        idle_in;
    logic [1:0]        st_idle;
    logic [1:0]        req_v;
    logic [1:0]        done_v;
    logic [1:0]        err_v;
    dma_fields_t [1:0] eng_desc;

    assign din       = '{typ: cmd_type,
                         f: '{addr: cmd_addr, len: cmd_len, num: cmd_num,
                              inc: cmd_inc, resp_addr: cmd_resp_addr}};
    assign cmd_ready = !full;
    // A descriptor offered during a flush cycle is dropped along with the queue.
    assign push      = cmd_valid && cmd_ready && !flush;
    assign disp      = !empty && !flush && st_idle[head.typ];

    mu_dma_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (disp),
        .flush (flush),
        .din   (din),
        .full  (full),
        .empty (empty),
        .head  (head)
    );

    assign idle_in[DMA_T_WR] = dma_wr_idle;
    assign idle_in[DMA_T_RD] = dma_rd_idle;

    for (genvar g = 0; g < 2; g++) begin : g_eng
        eng_st_t     st;
        eng_st_t     st_nxt;
        dma_fields_t cur;
        logic        go;
        logic        dn;
        logic        abort;

        assign go = disp && (head.typ == 1'(g));

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                st  <= ST_IDLE;
                cur <= '0;
            end else begin
                st <= st_nxt;
                if (go) cur <= head.f;
            end
        end

        always_comb begin
            st_nxt = st;
            dn     = 1'b0;
            case (st)
                ST_IDLE: if (go) st_nxt = ST_REQ;
                ST_REQ:  if (!idle_in[g]) st_nxt = ST_BUSY;
                ST_BUSY: if (idle_in[g]) begin
                    st_nxt = ST_IDLE;
                    dn     = 1'b1;
                end
                default: st_nxt = ST_IDLE;
            endcase
            // Watchdog abort overrides any normal transition and is never counted.
            if (abort) begin
                st_nxt = ST_IDLE;
                dn     = 1'b0;
            end
        end

`ifdef MU_DMA_TIMEOUT_EN
        localparam int TW = $clog2(TIMEOUT_CYC + 1);
        logic [TW-1:0] tcnt;
        logic          err;

        assign abort = (st != ST_IDLE) && (tcnt == TW'(TIMEOUT_CYC - 1));

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                tcnt <= '0;
                err  <= 1'b0;
            end else begin
                if (go)                 tcnt <= '0;
                else if (st != ST_IDLE) tcnt <= tcnt + 1'b1;
                if (abort)        err <= 1'b1;
                else if (irq_clr) err <= 1'b0;
            end
        end
        assign err_v[g] = err;
`else
        assign abort    = 1'b0;
        assign err_v[g] = 1'b0;
`endif

        assign st_idle[g]  = (st == ST_IDLE);
        assign req_v[g]    = (st == ST_REQ);
        assign done_v[g]   = dn;
        assign eng_desc[g] = cur;
    end

    assign dma_wr_req       = req_v[DMA_T_WR];
    assign dma_wr_reg_addr  = eng_desc[DMA_T_WR].addr;
    assign dma_wr_reg_len   = eng_desc[DMA_T_WR].len;
    assign dma_wr_reg_num   = eng_desc[DMA_T_WR].num;
    assign dma_wr_reg_inc   = eng_desc[DMA_T_WR].inc;
    assign dma_wr_resp_addr = eng_desc[DMA_T_WR].resp_addr;
    assign dma_rd_req       = req_v[DMA_T_RD];
    assign dma_rd_reg_addr  = eng_desc[DMA_T_RD].addr;
    assign dma_rd_reg_len   = eng_desc[DMA_T_RD].len;
    assign dma_rd_reg_num   = eng_desc[DMA_T_RD].num;
    assign dma_rd_reg_inc   = eng_desc[DMA_T_RD].inc;
    assign dma_rd_resp_addr = eng_desc[DMA_T_RD].resp_addr;
    assign err_wr           = err_v[DMA_T_WR];
    assign err_rd           = err_v[DMA_T_RD];

    assign busy = !empty || !st_idle[0] || !st_idle[1];

    logic [1:0]     ndone;
    logic [CNT_W:0] sum;
    logic           irq_src;

    assign ndone = {1'b0, done_v[0]} + {1'b0, done_v[1]};
    assign sum   = {1'b0, done_cnt} + (CNT_W+1)'(ndone);

`ifdef MU_DMA_TIMEOUT_EN
    assign irq_src = (done_cnt != '0) || err_wr || err_rd;
`else
    assign irq_src = (done_cnt != '0);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done_cnt  <= '0;
            interrupt <= 1'b0;
        end else begin
            if (irq_clr)        done_cnt <= CNT_W'(ndone);
            else if (sum[CNT_W]) done_cnt <= '1;
            else                 done_cnt <= sum[CNT_W-1:0];
            interrupt <= irq_en && irq_src;
        end
    end

endmodule
